// File: rtl/gbuff_out_drain_pkg.sv
// Shared definitions for the output-buffer drain engine: state encoding,
// row-offset thresholds, default widths and the word-count helper.
// No logic of its own; imported by gbuff_out_drain.
package gbuff_out_drain_pkg;

    localparam int DRAIN_DATA_WIDTH = 32;
    localparam int DRAIN_ADDR_WIDTH = 16;

    // Result columns beyond these thresholds spill into a 2nd / 3rd buffer word per row
    localparam logic [3:0] ROW_OFS_TH2 = 4'd5;
    localparam logic [3:0] ROW_OFS_TH3 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Words to drain: rows * words-per-row, 6-bit result (max 15*3 = 45).
    // An empty matrix (no rows or no columns) drains nothing.
    function automatic logic [5:0] calc_words(input logic [3:0] rows, input logic [3:0] cols);
        logic [1:0] words_per_row;
        if (cols == 4'd0)              words_per_row = 2'd0;
        else if (cols >= ROW_OFS_TH3)  words_per_row = 2'd3;
        else if (cols >= ROW_OFS_TH2)  words_per_row = 2'd2;
        else                           words_per_row = 2'd1;
        return {2'b00, rows} * {4'b0000, words_per_row};
    endfunction

endpackage

// File: rtl/gbuff_drain_fifo.sv
// 2-entry show-ahead FIFO: head word visible on dout while count != 0.
// Latency: push lands one cycle later (registered write); pop takes effect next edge.
// Backpressure: none internally; the caller keeps occupancy <= 2.
// Ports: clk/rst (async active-low), push/din write side, pop/dout read side, count occupancy.
module gbuff_drain_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/gbuff_out_drain.sv
// Drains W result words from the output global buffer in address order onto a valid/ready stream.
// Latency: start captured at edge t -> rd_en in the next cycle -> out_valid two cycles after that.
// Backpressure: reads are throttled so buffered + in-flight words never exceed 2; data held while stalled.
// Ports: clk, rst (async active-low), start/m/n command; rd_en/rd_addr/rd_data buffer read port;
//        out_valid/out_ready/out_data/out_last stream; busy/done status.
// Option: define GBUFF_DRAIN_BSWAP_EN to byte-reverse each word on the stream.
module gbuff_out_drain
    import gbuff_out_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DRAIN_DATA_WIDTH,
    parameter int ADDR_WIDTH = DRAIN_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            m,
    input  logic [3:0]            n,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    drain_state_t          r_state;
    logic [5:0]            r_words;
    logic [5:0]            r_addr;
    logic [5:0]            r_out_cnt;
    logic                  r_inflight;
    logic                  r_busy;
    logic                  r_done;

    logic [5:0]            w_words;
    logic [1:0]            w_fifo_cnt;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [2:0]            w_occ;
    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_last_rd;
    logic                  w_out_last;
    logic                  w_last_hs;

    assign w_words   = calc_words(m, n);
    assign w_pop     = out_valid && out_ready;
    // Occupancy after this cycle's pop; a new read only if it still fits in the 2-entry FIFO
    assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en   = (r_state == ST_RUN) && (w_occ < 3'd2);
    assign w_last_rd = w_rd_en && (r_addr == r_words - 6'd1);
    assign w_out_last = out_valid && (r_out_cnt == r_words - 6'd1);
    assign w_last_hs = w_pop && w_out_last;

    gbuff_drain_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .din   (rd_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_words    <= 6'd0;
            r_addr     <= 6'd0;
            r_out_cnt  <= 6'd0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 6'd1;
            end
            // Address parks on W-1 after the final read rather than running past the block
            if (w_rd_en && !w_last_rd) begin
                r_addr <= r_addr + 6'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_words   <= w_words;
                        r_addr    <= 6'd0;
                        r_out_cnt <= 6'd0;
                        r_busy    <= 1'b1;
                        r_state   <= (w_words == 6'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last_rd) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_last_hs) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // An empty transfer arrives with done low and spends one extra cycle here
                    // so its done pulse lands two cycles after start.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out_data = '0;
`ifdef GBUFF_DRAIN_BSWAP_EN
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            w_out_data[i*8 +: 8] = w_fifo_dout[DATA_WIDTH-8-i*8 +: 8];
        end
`else
        w_out_data = w_fifo_dout;
`endif
    end

    assign rd_en     = w_rd_en;
    assign rd_addr   = ADDR_WIDTH'(r_addr);
    assign out_valid = (w_fifo_cnt != 2'd0);
    assign out_data  = w_out_data;
    assign out_last  = w_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
